fft_peak_scheduler: RTL

//  Sequences fft_sm frames for the tuner: waits for Ready, issues Start, waits for Done,

---
 rtl/fft_peak_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fft_peak_scheduler.sv
// Frame sequencer for fft_sm: start handshake, done wait, bin sweep, peak report.
// No output backpressure; peak results are a 1-cycle PeakValid pulse and a stalled FFT trips a sticky watchdog.
module fft_peak_scheduler #(
  parameter int unsigned NBINS     = 128,
  parameter int unsigned FIRST_BIN = 1,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [15:0] MIN_MAG   = 16'd64,
  parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_fft_ready,
  input  logic        i_fft_done,
  output logic        o_fft_start,
  output logic [7:0]  o_inspect,
  input  logic [15:0] i_result,
  output logic [7:0]  o_peak_bin,
  output logic [15:0] o_peak_mag,
  output logic        o_peak_valid,
  output logic        o_no_signal,
  output logic        o_busy,
  output logic        o_error,
  output logic [15:0] o_frame_cnt
);

  localparam logic [7:0] LAST_BIN  = 8'(NBINS - 1);
  localparam logic [7:0] START_BIN = 8'(FIRST_BIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_WAIT_DONE,
    S_SCAN,
    S_REPORT
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [19:0] r_wdog;
  logic [7:0]  r_inspect;
  logic [7:0]  r_tag [READ_LAT];
  logic [READ_LAT-1:0] r_tag_vld;
  logic [15:0] r_max;
  logic [7:0]  r_max_bin;

  logic        r_fft_start;
  logic [7:0]  r_peak_bin;
  logic [15:0] r_peak_mag;
  logic        r_peak_valid;
  logic        r_no_signal;
  logic        r_busy;
  logic        r_error;
  logic [15:0] r_frame_cnt;

  logic        w_in_watch;
  logic        w_wdog_expire;
  logic        w_scanning;
  logic [7:0]  w_tag_bin;
  logic        w_tag_vld;
  logic        w_gt;
  logic [15:0] w_max_nxt;
  logic [7:0]  w_bin_nxt;
  logic        w_scan_done;

  assign w_in_watch    = (r_state == S_START) || (r_state == S_WAIT_DONE);
  assign w_wdog_expire = w_in_watch && (r_wdog == (TIMEOUT - 20'd1));
  assign w_scanning    = (r_state == S_SCAN);

  // The last pipeline stage pairs a bin index with the Result now on i_result.
  assign w_tag_bin   = r_tag[READ_LAT-1];
  assign w_tag_vld   = r_tag_vld[READ_LAT-1];
  assign w_gt        = w_scanning && w_tag_vld && (i_result > r_max);
  assign w_max_nxt   = w_gt ? i_result : r_max;
  assign w_bin_nxt   = w_gt ? w_tag_bin : r_max_bin;
  assign w_scan_done = w_scanning && w_tag_vld && (w_tag_bin == LAST_BIN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next_state = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (i_fft_ready) w_next_state = S_START;
      end
      S_START: begin
        if (w_wdog_expire)     w_next_state = S_IDLE;
        else if (!i_fft_ready) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_wdog_expire)   w_next_state = S_IDLE;
        else if (i_fft_done) w_next_state = S_SCAN;
      end
      S_SCAN: begin
        if (w_scan_done) w_next_state = S_REPORT;
      end
      S_REPORT: begin
        w_next_state = i_enable ? S_WAIT_RDY : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdog       <= '0;
      r_inspect    <= '0;
      r_tag_vld    <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) r_tag[i] <= '0;
      r_max        <= '0;
      r_max_bin    <= '0;
      r_fft_start  <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_peak_valid <= 1'b0;
      r_no_signal  <= 1'b1;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_busy       <= (w_next_state != S_IDLE);
      r_fft_start  <= (w_next_state == S_START);
      r_peak_valid <= (w_next_state == S_REPORT);

      if ((r_state == S_WAIT_RDY) && (w_next_state == S_START)) begin
        r_wdog <= '0;
      end else if (w_in_watch) begin
        r_wdog <= r_wdog + 20'd1;
      end

      if (w_wdog_expire) r_error <= 1'b1;

      if (w_next_state == S_SCAN) begin
        if (!w_scanning)                r_inspect <= START_BIN;
        else if (r_inspect != LAST_BIN) r_inspect <= r_inspect + 8'd1;
      end else begin
        r_inspect <= '0;
      end

      // Valid bits are flushed outside SCAN so a new sweep never sees stale tags.
      r_tag[0]     <= r_inspect;
      r_tag_vld[0] <= w_scanning;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        r_tag[i]     <= r_tag[i-1];
        r_tag_vld[i] <= w_scanning && r_tag_vld[i-1];
      end

      if ((r_state == S_WAIT_DONE) && (w_next_state == S_SCAN)) begin
        r_max     <= '0;
        r_max_bin <= START_BIN;
      end else if (w_scanning) begin
        r_max     <= w_max_nxt;
        r_max_bin <= w_bin_nxt;
      end

      if (w_scanning && (w_next_state == S_REPORT)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (w_max_nxt >= MIN_MAG) begin
          r_peak_bin  <= w_bin_nxt;
          r_peak_mag  <= w_max_nxt;
          r_no_signal <= 1'b0;
        end else begin
          r_no_signal <= 1'b1;
        end
      end
    end
  end

  assign o_fft_start  = r_fft_start;
  assign o_inspect    = r_inspect;
  assign o_peak_bin   = r_peak_bin;
  assign o_peak_mag   = r_peak_mag;
  assign o_peak_valid = r_peak_valid;
  assign o_no_signal  = r_no_signal;
  assign o_busy       = r_busy;
  assign o_error      = r_error;
  assign o_frame_cnt  = r_frame_cnt;

endmodule
